// File: rtl/vlc_byte_serializer.sv
// Frame serializer: START(0), DATA_W bits MSB first, optional even-parity bit, STOP(1),
// each bit held BIT_CYCLES clocks. Define VLC_SER_PARITY_EN to insert the parity bit.
module vlc_byte_serializer #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx_bit,
    output logic              tx_en,
    output logic              busy,
    output logic              done
);

    localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]        BC_LAST  = 8'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef VLC_SER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic               rdy;
    logic               bit_last;

    assign bit_last  = (cnt_q == BC_LAST);
    // Ready is forced low while reset is asserted, even though the FSM already sits in IDLE.
    assign din_ready = rst & rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        tx_bit  = 1'b1;
        tx_en   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        rdy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                rdy  = 1'b1;
                if (din_valid) begin
                    sh_d    = din;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_bit = 1'b0;
                tx_en  = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (bit_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_bit = sh_q[DATA_W-1];
                tx_en  = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (bit_last) begin
                    cnt_d = '0;
                    // Rotate rather than shift so the captured word is intact after DATA.
                    sh_d  = (sh_q << 1) | (sh_q >> (DATA_W - 1));
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef VLC_SER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
`ifdef VLC_SER_PARITY_EN
            S_PARITY: begin
                tx_bit = ^sh_q;
                tx_en  = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (bit_last) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                tx_bit = 1'b1;
                tx_en  = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (bit_last) begin
                    done  = 1'b1;
                    rdy   = 1'b1;
                    cnt_d = '0;
                    if (din_valid) begin
                        sh_d    = din;
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vlc_byte_serializer.sv
// Directed bench: main instance at BIT_CYCLES=4, second instance at BIT_CYCLES=1.
module tb_vlc_byte_serializer;

`ifdef VLC_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int BC  = 4;
    localparam int FB  = 10 + PAR;   // frame bits
    localparam int L   = FB * BC;    // frame cycles, main instance

    logic       clk, rst;
    logic [7:0] din, din1;
    logic       din_valid, din_valid1;
    logic       din_ready, tx_bit, tx_en, busy, done;
    logic       din_ready1, tx_bit1, tx_en1, busy1, done1;
    int         checks, errors;

    vlc_byte_serializer #(.DATA_W(8), .BIT_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .tx_bit(tx_bit), .tx_en(tx_en), .busy(busy), .done(done)
    );

    vlc_byte_serializer #(.DATA_W(8), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
        .tx_bit(tx_bit1), .tx_en(tx_en1), .busy(busy1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected line level for frame bit i of word w.
    function automatic logic frame_bit(input logic [7:0] w, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return w[8 - i];
        if (PAR == 1 && i == 9) return ^w;
        return 1'b1;
    endfunction

    task automatic test_reset();
        logic [4:0] obs;
        rst = 1'b0; din = 8'h00; din_valid = 1'b1; din1 = 8'h00; din_valid1 = 1'b0;
        #1;
        obs = {tx_bit, tx_en, busy, done, din_ready};
        checks++;
        if (obs !== 5'b10000) begin
            errors++; $display("FAIL reset_async got %b exp %b", obs, 5'b10000);
        end
        repeat (3) @(negedge clk);
        obs = {tx_bit, tx_en, busy, done, din_ready};
        checks++;
        if (obs !== 5'b10000) begin
            errors++; $display("FAIL reset_hold got %b exp %b", obs, 5'b10000);
        end
        din_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        obs = {tx_bit, tx_en, busy, done, din_ready};
        checks++;
        if (obs !== 5'b10001) begin
            errors++; $display("FAIL reset_release got %b exp %b", obs, 5'b10001);
        end
    endtask

    // One isolated frame; samples every cycle until the FSM is back in IDLE.
    task automatic test_single(input logic [7:0] w);
        logic [4:0] obs, exp;
        int k;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL single_idle_ready w=%h got %b exp 1", w, din_ready);
        end
        din = w; din_valid = 1'b1;
        for (int c = 1; c <= L + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                din_valid = 1'b0; din = ~w;
            end
            k = c - 1;
            if (c <= L) exp = {frame_bit(w, k / BC), 1'b1, 1'b1, k == L - 1, k == L - 1};
            else        exp = 5'b10001;
            obs = {tx_bit, tx_en, busy, done, din_ready};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL single w=%h cyc=%0d got %b exp %b", w, c, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] obs, exp;
        logic [7:0] w;
        int k;
        @(negedge clk);
        din = 8'h3C; din_valid = 1'b1;
        for (int c = 1; c <= 2 * L + 1; c++) begin
            @(negedge clk);
            w = (c <= L) ? 8'h3C : 8'hC3;
            k = (c <= L) ? c - 1 : c - 1 - L;
            if (c <= 2 * L) exp = {frame_bit(w, k / BC), 1'b1, 1'b1, k == L - 1, k == L - 1};
            else            exp = 5'b10001;
            obs = {tx_bit, tx_en, busy, done, din_ready};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL b2b cyc=%0d got %b exp %b", c, obs, exp);
            end
            if (c == 1) din = 8'hC3;
            if (c == L + 1) din_valid = 1'b0;
        end
    endtask

    task automatic test_din_ignored();
        logic [4:0] obs, exp;
        int k;
        @(negedge clk);
        din = 8'h81; din_valid = 1'b1;
        for (int c = 1; c <= L + 1; c++) begin
            @(negedge clk);
            k = c - 1;
            if (c <= L) exp = {frame_bit(8'h81, k / BC), 1'b1, 1'b1, k == L - 1, k == L - 1};
            else        exp = 5'b10001;
            obs = {tx_bit, tx_en, busy, done, din_ready};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL din_ignored cyc=%0d got %b exp %b", c, obs, exp);
            end
            din = 8'(c * 8'h5B);
            if (c >= L) din_valid = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        logic [4:0] obs, exp;
        @(negedge clk);
        din = 8'hFF; din_valid = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1) din_valid = 1'b0;
        end
        exp = {frame_bit(8'hFF, 16 / BC), 1'b1, 1'b1, 1'b0, 1'b0};
        obs = {tx_bit, tx_en, busy, done, din_ready};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL mid_reset_pre got %b exp %b", obs, exp);
        end
        #2 rst = 1'b0;
        #1;
        obs = {tx_bit, tx_en, busy, done, din_ready};
        checks++;
        if (obs !== 5'b10000) begin
            errors++; $display("FAIL mid_reset_async got %b exp %b", obs, 5'b10000);
        end
        din_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            obs = {tx_bit, tx_en, busy, done, din_ready};
            checks++;
            if (obs !== 5'b10000) begin
                errors++; $display("FAIL mid_reset_hold got %b exp %b", obs, 5'b10000);
            end
        end
        din_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        obs = {tx_bit, tx_en, busy, done, din_ready};
        checks++;
        if (obs !== 5'b10001) begin
            errors++; $display("FAIL mid_reset_release got %b exp %b", obs, 5'b10001);
        end
    endtask

    task automatic test_bc1();
        logic [4:0] obs, exp;
        @(negedge clk);
        din1 = 8'h55; din_valid1 = 1'b1;
        for (int c = 1; c <= FB + 1; c++) begin
            @(negedge clk);
            if (c == 1) din_valid1 = 1'b0;
            if (c <= FB) exp = {frame_bit(8'h55, c - 1), 1'b1, 1'b1, c == FB, c == FB};
            else         exp = 5'b10001;
            obs = {tx_bit1, tx_en1, busy1, done1, din_ready1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL bc1 cyc=%0d got %b exp %b", c, obs, exp);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_single(8'hA5);
        test_single(8'h07);
        test_back_to_back();
        test_din_ignored();
        test_mid_reset();
        test_single(8'h5A);
        test_bc1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
